// File: rtl/m_dmem_arbiter.sv
// m_dmem_arbiter: shares one single-port synchronous data memory between the
// pipeline MEM stage (processor) and a debug/loader port.
// Processor has priority; a saturating wait counter bounds debug starvation,
// and debug may lock the bus for bursts.
// Ports:
//   w_clk, w_rst_n                    clock, async active-low reset
//   w_p_req/we/addr/wdata             processor request
//   w_p_gnt/stall/rvalid/rdata        processor grant (comb), stall, read return
//   w_d_req/we/addr/wdata/lock        debug request and bus-lock
//   w_d_gnt/rvalid/rdata              debug grant (comb), read return
//   w_m_addr/we/din, w_m_dout         memory side (one-cycle registered read)
module m_dmem_arbiter #(
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    input  logic          w_p_req,
    input  logic          w_p_we,
    input  logic [AW-1:0] w_p_addr,
    input  logic [DW-1:0] w_p_wdata,
    output logic          w_p_gnt,
    output logic          w_p_stall,
    output logic          w_p_rvalid,
    output logic [DW-1:0] w_p_rdata,
    input  logic          w_d_req,
    input  logic          w_d_we,
    input  logic [AW-1:0] w_d_addr,
    input  logic [DW-1:0] w_d_wdata,
    input  logic          w_d_lock,
    output logic          w_d_gnt,
    output logic          w_d_rvalid,
    output logic [DW-1:0] w_d_rdata,
    output logic [AW-1:0] w_m_addr,
    output logic          w_m_we,
    output logic [DW-1:0] w_m_din,
    input  logic [DW-1:0] w_m_dout
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_PPRI   = 2'd0,
        S_DFORCE = 2'd1,
        S_DLOCK  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_nxt;
    logic          p_gnt, d_gnt;

    // State and wait counter registers
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state    <= S_PPRI;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Grant decision, wait counter update and next state
    always_comb begin
        p_gnt     = 1'b0;
        d_gnt     = 1'b0;
        state_nxt = state;
        wait_nxt  = wait_cnt;

        case (state)
            S_PPRI: begin
                p_gnt = w_p_req;
                d_gnt = w_d_req & ~w_p_req;
            end
            S_DFORCE: begin
                d_gnt = w_d_req;
                p_gnt = w_p_req & ~w_d_req;
            end
            S_DLOCK: begin
                d_gnt = w_d_req;
            end
            default: ;
        endcase

        // Grants are suppressed while reset is held
        if (!w_rst_n) begin
            p_gnt = 1'b0;
            d_gnt = 1'b0;
        end

        if (d_gnt || !w_d_req) begin
            wait_nxt = '0;
        end else if (wait_cnt < WAIT_MAX) begin
            wait_nxt = wait_cnt + CW'(1);
        end

        case (state)
            S_PPRI: begin
                // Force debug next cycle once it has waited MAX_WAIT cycles
                if (wait_nxt == WAIT_MAX) state_nxt = S_DFORCE;
            end
            S_DFORCE: begin
                if (d_gnt || !w_d_req) state_nxt = S_PPRI;
            end
            S_DLOCK: begin
                // Release wins over re-lock in the same cycle
                if (!w_d_lock) state_nxt = S_PPRI;
            end
            default: state_nxt = S_PPRI;
        endcase

        if (d_gnt && w_d_lock && state != S_DLOCK) begin
            state_nxt = S_DLOCK;
            wait_nxt  = '0;
        end
    end

    assign w_p_gnt   = p_gnt;
    assign w_d_gnt   = d_gnt;
    assign w_p_stall = w_p_req & ~p_gnt;

    // Memory mux: granted requester drives, idle bus is all zeros
    assign w_m_addr = p_gnt ? w_p_addr  : (d_gnt ? w_d_addr  : '0);
    assign w_m_din  = p_gnt ? w_p_wdata : (d_gnt ? w_d_wdata : '0);
    assign w_m_we   = (p_gnt & w_p_we) | (d_gnt & w_d_we);

    // Read-return tracking: memory data arrives one cycle after the grant
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_p_rvalid <= 1'b0;
            w_d_rvalid <= 1'b0;
        end else begin
            w_p_rvalid <= p_gnt & ~w_p_we;
            w_d_rvalid <= d_gnt & ~w_d_we;
        end
    end

    assign w_p_rdata = w_p_rvalid ? w_m_dout : '0;
    assign w_d_rdata = w_d_rvalid ? w_m_dout : '0;

endmodule

// File: tb/tb_m_dmem_arbiter.sv
// Directed self-checking bench for m_dmem_arbiter with a 4K x 32 memory model.
module tb_m_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_req, p_we, d_req, d_we, d_lock;
    logic [11:0] p_addr, d_addr;
    logic [31:0] p_wdata, d_wdata;
    logic        p_gnt, p_stall, p_rvalid, d_gnt, d_rvalid;
    logic [31:0] p_rdata, d_rdata;
    logic [11:0] m_addr;
    logic        m_we;
    logic [31:0] m_din, m_dout;

    // Second instance with MAX_WAIT = 1 sharing the same stimulus
    logic        p_gnt1, p_stall1, p_rvalid1, d_gnt1, d_rvalid1, m_we1;
    logic [31:0] p_rdata1, d_rdata1, m_din1;
    logic [11:0] m_addr1;

    int errors = 0;
    int checks = 0;

    m_dmem_arbiter #(.AW(12), .DW(32), .MAX_WAIT(8)) u_dut (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_p_req(p_req), .w_p_we(p_we), .w_p_addr(p_addr), .w_p_wdata(p_wdata),
        .w_p_gnt(p_gnt), .w_p_stall(p_stall), .w_p_rvalid(p_rvalid), .w_p_rdata(p_rdata),
        .w_d_req(d_req), .w_d_we(d_we), .w_d_addr(d_addr), .w_d_wdata(d_wdata),
        .w_d_lock(d_lock), .w_d_gnt(d_gnt), .w_d_rvalid(d_rvalid), .w_d_rdata(d_rdata),
        .w_m_addr(m_addr), .w_m_we(m_we), .w_m_din(m_din), .w_m_dout(m_dout)
    );

    m_dmem_arbiter #(.AW(12), .DW(32), .MAX_WAIT(1)) u_dut1 (
        .w_clk(clk), .w_rst_n(rst_n),
        .w_p_req(p_req), .w_p_we(p_we), .w_p_addr(p_addr), .w_p_wdata(p_wdata),
        .w_p_gnt(p_gnt1), .w_p_stall(p_stall1), .w_p_rvalid(p_rvalid1), .w_p_rdata(p_rdata1),
        .w_d_req(d_req), .w_d_we(d_we), .w_d_addr(d_addr), .w_d_wdata(d_wdata),
        .w_d_lock(d_lock), .w_d_gnt(d_gnt1), .w_d_rvalid(d_rvalid1), .w_d_rdata(d_rdata1),
        .w_m_addr(m_addr1), .w_m_we(m_we1), .w_m_din(m_din1), .w_m_dout(m_dout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory, read-first
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (m_we) mem[m_addr] <= m_din;
        m_dout <= mem[m_addr];
    end

    task automatic drive(input logic pr, input logic pw, input logic [11:0] pa,
                         input logic [31:0] pd, input logic dr, input logic dw,
                         input logic [11:0] da, input logic [31:0] dd, input logic dl);
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_lock = dl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 12'd0, 32'd0, 0, 0, 12'd0, 32'd0, 0);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 12'd3, 32'h55, 1, 1, 12'd4, 32'h66, 1);
        @(negedge clk);
        checks++; if (p_gnt !== 1'b0) begin errors++; $display("FAIL rst_p_gnt got=%b want=0", p_gnt); end
        checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt got=%b want=0", d_gnt); end
        checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL rst_m_we got=%b want=0", m_we); end
        checks++; if (p_stall !== 1'b1) begin errors++; $display("FAIL rst_p_stall got=%b want=1", p_stall); end
        checks++; if (p_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b%b want=00", p_rvalid, d_rvalid); end
        p_req = 1'b0;
        #1;
        checks++; if (p_stall !== 1'b0) begin errors++; $display("FAIL rst_p_stall_noreq got=%b want=0", p_stall); end
        tick();
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_proc_only();
        drive(1, 1, 12'd5, 32'hDEADBEEF, 0, 0, 12'd0, 32'd0, 0);
        @(negedge clk);
        checks++; if (p_gnt !== 1'b1 || p_stall !== 1'b0) begin errors++; $display("FAIL po_store_gnt got=%b/%b want=1/0", p_gnt, p_stall); end
        checks++; if (m_we !== 1'b1 || m_addr !== 12'd5 || m_din !== 32'hDEADBEEF) begin errors++; $display("FAIL po_store_bus got=%b %h %h want=1 005 deadbeef", m_we, m_addr, m_din); end
        tick();
        drive(1, 0, 12'd5, 32'd0, 0, 0, 12'd0, 32'd0, 0);
        @(negedge clk);
        checks++; if (p_gnt !== 1'b1 || p_stall !== 1'b0) begin errors++; $display("FAIL po_load_gnt got=%b/%b want=1/0", p_gnt, p_stall); end
        checks++; if (p_rvalid !== 1'b0) begin errors++; $display("FAIL po_store_no_rvalid got=%b want=0", p_rvalid); end
        tick();
        drive(0, 0, 12'd0, 32'd0, 0, 0, 12'd0, 32'd0, 0);
        @(negedge clk);
        checks++; if (p_rvalid !== 1'b1 || p_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL po_load_data got=%b %h want=1 deadbeef", p_rvalid, p_rdata); end
        checks++; if (d_rvalid !== 1'b0 || d_rdata !== 32'd0) begin errors++; $display("FAIL po_d_quiet got=%b %h want=0 0", d_rvalid, d_rdata); end
        checks++; if (m_addr !== 12'd0 || m_we !== 1'b0 || m_din !== 32'd0) begin errors++; $display("FAIL po_idle_bus got=%h %b %h want=0 0 0", m_addr, m_we, m_din); end
        tick();
    endtask

    task automatic test_contention();
        drive(1, 0, 12'd5, 32'd0, 1, 0, 12'd5, 32'd0, 0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 9) begin
                checks++; if (p_gnt !== 1'b0 || d_gnt !== 1'b1 || p_stall !== 1'b1) begin errors++; $display("FAIL ct_force c=%0d got p=%b d=%b s=%b want 0 1 1", c, p_gnt, d_gnt, p_stall); end
            end else begin
                checks++; if (p_gnt !== 1'b1 || d_gnt !== 1'b0 || p_stall !== 1'b0) begin errors++; $display("FAIL ct_ppri c=%0d got p=%b d=%b s=%b want 1 0 0", c, p_gnt, d_gnt, p_stall); end
            end
            if (c == 10) begin
                checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF || p_rvalid !== 1'b0) begin errors++; $display("FAIL ct_d_read got=%b %h p=%b want=1 deadbeef 0", d_rvalid, d_rdata, p_rvalid); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_lock_burst();
        drive(1, 0, 12'd5, 32'd0, 1, 1, 12'd0, 32'h1000, 1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if (p_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL lb_wait c=%0d got p=%b d=%b want 1 0", c, p_gnt, d_gnt); end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            d_addr = 12'(i);
            d_wdata = 32'h1000 + 32'(i);
            @(negedge clk);
            checks++; if (d_gnt !== 1'b1 || p_stall !== 1'b1 || p_gnt !== 1'b0) begin errors++; $display("FAIL lb_burst i=%0d got d=%b s=%b p=%b want 1 1 0", i, d_gnt, p_stall, p_gnt); end
            checks++; if (m_we !== 1'b1 || m_addr !== 12'(i) || m_din !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL lb_bus i=%0d got %b %h %h", i, m_we, m_addr, m_din); end
            tick();
        end
        drive(1, 0, 12'd5, 32'd0, 0, 0, 12'd0, 32'd0, 0);
        @(negedge clk);
        checks++; if (d_gnt !== 1'b0 || m_we !== 1'b0) begin errors++; $display("FAIL lb_release got d=%b we=%b want 0 0", d_gnt, m_we); end
        tick();
        @(negedge clk);
        checks++; if (p_gnt !== 1'b1 || p_stall !== 1'b0) begin errors++; $display("FAIL lb_after got p=%b s=%b want 1 0", p_gnt, p_stall); end
        tick();
        // Back-to-back processor reads of the burst data
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive(1, 0, 12'(i), 32'd0, 0, 0, 12'd0, 32'd0, 0);
            else       drive(0, 0, 12'd0, 32'd0, 0, 0, 12'd0, 32'd0, 0);
            @(negedge clk);
            if (i > 0) begin
                checks++; if (p_rvalid !== 1'b1 || p_rdata !== 32'h1000 + 32'(i - 1)) begin errors++; $display("FAIL lb_readback i=%0d got %b %h want 1 %h", i - 1, p_rvalid, p_rdata, 32'h1000 + 32'(i - 1)); end
            end
            tick();
        end
    endtask

    task automatic test_idle_lock();
        drive(0, 0, 12'd0, 32'd0, 1, 0, 12'd0, 32'd0, 1);
        @(negedge clk);
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL il_enter got d=%b want 1", d_gnt); end
        tick();
        drive(1, 1, 12'd9, 32'h99, 0, 0, 12'd0, 32'd0, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (m_we !== 1'b0 || p_gnt !== 1'b0 || p_stall !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL il_hold c=%0d got we=%b p=%b s=%b d=%b", c, m_we, p_gnt, p_stall, d_gnt); end
            if (c == 0) begin
                checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1000) begin errors++; $display("FAIL il_read got %b %h want 1 00001000", d_rvalid, d_rdata); end
            end
            tick();
        end
        d_lock = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (p_gnt !== 1'b1 || m_we !== 1'b1 || m_addr !== 12'd9) begin errors++; $display("FAIL il_exit got p=%b we=%b a=%h want 1 1 009", p_gnt, m_we, m_addr); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_lock();
        drive(0, 0, 12'd0, 32'd0, 1, 0, 12'd1, 32'd0, 1);
        @(negedge clk);
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rl_grant1 got %b want 1", d_gnt); end
        tick();
        drive(1, 0, 12'd5, 32'd0, 1, 0, 12'd2, 32'd0, 1);
        @(negedge clk);
        checks++; if (d_gnt !== 1'b1 || p_stall !== 1'b1) begin errors++; $display("FAIL rl_grant2 got d=%b s=%b want 1 1", d_gnt, p_stall); end
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1001) begin errors++; $display("FAIL rl_read1 got %b %h want 1 00001001", d_rvalid, d_rdata); end
        rst_n = 1'b0;
        #1;
        checks++; if (d_rvalid !== 1'b0 || d_gnt !== 1'b0 || p_stall !== 1'b1) begin errors++; $display("FAIL rl_in_reset got rv=%b d=%b s=%b want 0 0 1", d_rvalid, d_gnt, p_stall); end
        @(negedge clk);
        checks++; if (d_rvalid !== 1'b0 || p_rvalid !== 1'b0) begin errors++; $display("FAIL rl_pending got %b %b want 0 0", d_rvalid, p_rvalid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (p_gnt !== 1'b1 || d_gnt !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rl_release got p=%b d=%b rv=%b want 1 0 0", p_gnt, d_gnt, d_rvalid); end
        tick();
        @(negedge clk);
        checks++; if (p_gnt !== 1'b1 || p_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rl_ppri got p=%b prv=%b drv=%b want 1 1 0", p_gnt, p_rvalid, d_rvalid); end
        tick();
        idle();
    endtask

    task automatic test_rw_interleave();
        drive(1, 1, 12'd7, 32'h0000_0777, 0, 0, 12'd0, 32'd0, 0);
        tick();
        drive(0, 0, 12'd0, 32'd0, 1, 0, 12'd7, 32'd0, 0);
        @(negedge clk);
        checks++; if (d_gnt !== 1'b1 || m_addr !== 12'd7) begin errors++; $display("FAIL rw_d_gnt got %b %h want 1 007", d_gnt, m_addr); end
        tick();
        drive(1, 1, 12'd7, 32'hABCD_0007, 0, 0, 12'd0, 32'd0, 0);
        @(negedge clk);
        checks++; if (p_gnt !== 1'b1 || m_we !== 1'b1) begin errors++; $display("FAIL rw_p_store got %b %b want 1 1", p_gnt, m_we); end
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0000_0777) begin errors++; $display("FAIL rw_old_data got %b %h want 1 00000777", d_rvalid, d_rdata); end
        tick();
        drive(1, 0, 12'd7, 32'd0, 0, 0, 12'd0, 32'd0, 0);
        tick();
        drive(0, 0, 12'd0, 32'd0, 0, 0, 12'd0, 32'd0, 0);
        @(negedge clk);
        checks++; if (p_rvalid !== 1'b1 || p_rdata !== 32'hABCD_0007) begin errors++; $display("FAIL rw_new_data got %b %h want 1 abcd0007", p_rvalid, p_rdata); end
        tick();
    endtask

    task automatic test_max_wait1();
        drive(1, 0, 12'd5, 32'd0, 1, 0, 12'd5, 32'd0, 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++; if (p_gnt1 !== 1'b0 || d_gnt1 !== 1'b1 || p_stall1 !== 1'b1) begin errors++; $display("FAIL mw1 c=%0d got p=%b d=%b s=%b want 0 1 1", c, p_gnt1, d_gnt1, p_stall1); end
            end else begin
                checks++; if (p_gnt1 !== 1'b1 || d_gnt1 !== 1'b0) begin errors++; $display("FAIL mw1 c=%0d got p=%b d=%b want 1 0", c, p_gnt1, d_gnt1); end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        drive(0, 0, 12'd0, 32'd0, 0, 0, 12'd0, 32'd0, 0);
        rst_n = 1'b0;
        test_reset();
        test_proc_only();
        test_contention();
        test_lock_burst();
        test_idle_lock();
        test_reset_mid_lock();
        test_rw_interleave();
        test_max_wait1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
